// File: rtl/clock_ctrl.sv
// HH:MM:SS BCD time keeper with RUN / SET_HR / SET_MIN mode FSM, idle timeout and blink strobes.
// Latency: one cycle; every output is registered and reflects tick/buttons sampled at the previous edge.
// Backpressure: none; tick and button presses are acted on in the cycle they are sampled.
module clock_ctrl #(
  parameter int unsigned SET_TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] hr_t,
  output logic [3:0] hr_u,
  output logic [2:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(SET_TIMEOUT);

  state_t     state, state_nxt;
  logic       btn_mode_q, btn_inc_q;
  logic       mode_press, inc_press;
  logic [7:0] idle_cnt, idle_nxt;
  logic       phase, phase_nxt;
  logic       day_nxt;

  logic [1:0] hr_t_n, hr_inc_t;
  logic [3:0] hr_u_n, hr_inc_u;
  logic [2:0] min_t_n, min_inc_t;
  logic [3:0] min_u_n, min_inc_u;
  logic [2:0] sec_t_n, sec_inc_t;
  logic [3:0] sec_u_n, sec_inc_u;
  logic       min_top, sec_top, hr_top;

  // Rising-edge detect; the registered copies reset high so a button held through reset is not a press.
  assign mode_press = btn_mode & ~btn_mode_q;
  assign inc_press  = btn_inc & ~btn_inc_q;

  assign hr_top  = (hr_t == 2'd2) && (hr_u == 4'd3);
  assign min_top = (min_t == 3'd5) && (min_u == 4'd9);
  assign sec_top = (sec_t == 3'd5) && (sec_u == 4'd9);

  // Single-step BCD increments of each field, each wrapping at its own limit.
  always_comb begin
    hr_inc_t  = hr_t;
    hr_inc_u  = hr_u + 4'd1;
    min_inc_t = min_t;
    min_inc_u = min_u + 4'd1;
    sec_inc_t = sec_t;
    sec_inc_u = sec_u + 4'd1;
    if (hr_top) begin
      hr_inc_t = 2'd0;
      hr_inc_u = 4'd0;
    end else if (hr_u == 4'd9) begin
      hr_inc_t = hr_t + 2'd1;
      hr_inc_u = 4'd0;
    end
    if (min_u == 4'd9) begin
      min_inc_u = 4'd0;
      min_inc_t = (min_t == 3'd5) ? 3'd0 : min_t + 3'd1;
    end
    if (sec_u == 4'd9) begin
      sec_inc_u = 4'd0;
      sec_inc_t = (sec_t == 3'd5) ? 3'd0 : sec_t + 3'd1;
    end
  end

  // Mode FSM next state plus the time, idle counter, blink phase and day strobe it controls.
  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    phase_nxt = phase;
    day_nxt   = 1'b0;
    hr_t_n    = hr_t;
    hr_u_n    = hr_u;
    min_t_n   = min_t;
    min_u_n   = min_u;
    sec_t_n   = sec_t;
    sec_u_n   = sec_u;
    case (state)
      RUN: begin
        idle_nxt  = 8'd0;
        phase_nxt = 1'b0;
        if (mode_press) begin
          // The tick of this cycle is dropped so time does not move on entry.
          state_nxt = SET_HR;
        end else if (tick) begin
          sec_t_n = sec_inc_t;
          sec_u_n = sec_inc_u;
          if (sec_top) begin
            min_t_n = min_inc_t;
            min_u_n = min_inc_u;
            if (min_top) begin
              hr_t_n  = hr_inc_t;
              hr_u_n  = hr_inc_u;
              day_nxt = hr_top;
            end
          end
        end
      end
      SET_HR, SET_MIN: begin
        if (mode_press) begin
          // Mode wins over a simultaneous inc press.
          idle_nxt  = 8'd0;
          phase_nxt = 1'b0;
          if (state == SET_HR) begin
            state_nxt = SET_MIN;
          end else begin
            state_nxt = RUN;
            sec_t_n   = 3'd0;
            sec_u_n   = 4'd0;
          end
        end else if (inc_press) begin
          // An inc press also absorbs a coincident tick: no idle count, no blink toggle.
          idle_nxt  = 8'd0;
          phase_nxt = 1'b0;
          if (state == SET_HR) begin
            hr_t_n = hr_inc_t;
            hr_u_n = hr_inc_u;
          end else begin
            min_t_n = min_inc_t;
            min_u_n = min_inc_u;
          end
        end else if (tick) begin
          if (idle_cnt + 8'd1 == TIMEOUT_CNT) begin
            state_nxt = RUN;
            idle_nxt  = 8'd0;
            phase_nxt = 1'b0;
            sec_t_n   = 3'd0;
            sec_u_n   = 4'd0;
          end else begin
            idle_nxt  = idle_cnt + 8'd1;
            phase_nxt = ~phase;
          end
        end
      end
      default: begin
        state_nxt = RUN;
        idle_nxt  = 8'd0;
        phase_nxt = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Time, button history, idle/blink bookkeeping and registered display strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_mode_q <= 1'b1;
      btn_inc_q  <= 1'b1;
      idle_cnt   <= 8'd0;
      phase      <= 1'b0;
      hr_t       <= 2'd0;
      hr_u       <= 4'd0;
      min_t      <= 3'd0;
      min_u      <= 4'd0;
      sec_t      <= 3'd0;
      sec_u      <= 4'd0;
      blank_hr   <= 1'b0;
      blank_min  <= 1'b0;
      day_pulse  <= 1'b0;
    end else begin
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
      idle_cnt   <= idle_nxt;
      phase      <= phase_nxt;
      hr_t       <= hr_t_n;
      hr_u       <= hr_u_n;
      min_t      <= min_t_n;
      min_u      <= min_u_n;
      sec_t      <= sec_t_n;
      sec_u      <= sec_u_n;
      blank_hr   <= (state_nxt == SET_HR) && phase_nxt;
      blank_min  <= (state_nxt == SET_MIN) && phase_nxt;
      day_pulse  <= day_nxt;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: a decimal reference model feeds a scoreboard queue every cycle.
// Expected outputs are pushed when stimulus is driven and compared one edge later.
// Extra directed checks cover the time-setting, timeout, blink and reset scenarios.
module tb_clock_ctrl;

  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [1:0] hr_t;
  logic [3:0] hr_u;
  logic [2:0] min_t;
  logic [3:0] min_u;
  logic [2:0] sec_t;
  logic [3:0] sec_u;
  logic [1:0] mode;
  logic       blank_hr, blank_min, day_pulse;

  clock_ctrl #(.SET_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hr_t(hr_t), .hr_u(hr_u), .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
    .mode(mode), .blank_hr(blank_hr), .blank_min(blank_min), .day_pulse(day_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hrt, hru, mnt, mnu, sct, scu, md, bh, bm, day;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, in plain decimal.
  int hh = 0, mm = 0, ss = 0, md = 0, idle = 0;
  bit ph = 0, pbm = 1, pbi = 1, day = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit tk, input bit bm, input bit bi);
    bit mp, ip;
    int secs;
    if (rst) begin
      hh = 0; mm = 0; ss = 0; md = 0; idle = 0; ph = 0; pbm = 1; pbi = 1; day = 0;
      return;
    end
    mp  = bm && !pbm;
    ip  = bi && !pbi;
    pbm = bm;
    pbi = bi;
    day = 0;
    if (md == 0) begin
      if (mp) begin
        md = 1; idle = 0; ph = 0;
      end else if (tk) begin
        secs = hh * 3600 + mm * 60 + ss + 1;
        if (secs == 86400) begin
          secs = 0;
          day  = 1;
        end
        hh = secs / 3600;
        mm = (secs / 60) % 60;
        ss = secs % 60;
      end
    end else begin
      if (mp) begin
        idle = 0; ph = 0;
        if (md == 1) md = 2;
        else begin
          md = 0; ss = 0;
        end
      end else if (ip) begin
        idle = 0; ph = 0;
        if (md == 1) hh = (hh + 1) % 24;
        else         mm = (mm + 1) % 60;
      end else if (tk) begin
        idle++;
        if (idle == TO) begin
          md = 0; ss = 0; idle = 0; ph = 0;
        end else begin
          ph = !ph;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, record the model's prediction, return just after the edge.
  task automatic step(input bit rst, input bit tk, input bit bm, input bit bi);
    exp_t e;
    @(negedge clk);
    reset = rst; tick = tk; btn_mode = bm; btn_inc = bi;
    model(rst, tk, bm, bi);
    e.hrt = hh / 10; e.hru = hh % 10;
    e.mnt = mm / 10; e.mnu = mm % 10;
    e.sct = ss / 10; e.scu = ss % 10;
    e.md  = md;
    e.bh  = (md == 1 && ph) ? 1 : 0;
    e.bm  = (md == 2 && ph) ? 1 : 0;
    e.day = day ? 1 : 0;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic do_tick();
    step(0, 1, 0, 0);
  endtask

  task automatic idle_cycle();
    step(0, 0, 0, 0);
  endtask

  task automatic press_mode();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic press_inc();
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_hr"},  hr_t * 10 + hr_u,   h);
    check({tag, "_min"}, min_t * 10 + min_u, m);
    check({tag, "_sec"}, sec_t * 10 + sec_u, s);
  endtask

  // Scoreboard: compare every output one time unit after the edge that produced it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_hr_t",  hr_t,      e.hrt);
      check("sb_hr_u",  hr_u,      e.hru);
      check("sb_min_t", min_t,     e.mnt);
      check("sb_min_u", min_u,     e.mnu);
      check("sb_sec_t", sec_t,     e.sct);
      check("sb_sec_u", sec_u,     e.scu);
      check("sb_mode",  mode,      e.md);
      check("sb_bhr",   blank_hr,  e.bh);
      check("sb_bmin",  blank_min, e.bm);
      check("sb_day",   day_pulse, e.day);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_time("reset", 0, 0, 0);
    check("reset_mode", mode, 0);
    check("reset_day", day_pulse, 0);

    // 61 ticks from reset.
    for (int i = 0; i < 61; i++) begin
      do_tick();
      idle_cycle();
    end
    check_time("t61", 0, 1, 1);

    // Walk to 23:59:58 through the set modes, then roll the day over.
    press_mode();
    for (int i = 0; i < 23; i++) press_inc();
    press_mode();
    for (int i = 0; i < 58; i++) press_inc();
    press_mode();
    check_time("set2359", 23, 59, 0);
    for (int i = 0; i < 58; i++) begin
      do_tick();
      idle_cycle();
    end
    check_time("pre_roll", 23, 59, 58);
    do_tick();
    idle_cycle();
    do_tick();
    check_time("rollover", 0, 0, 0);
    check("day_hi", day_pulse, 1);
    idle_cycle();
    check("day_lo", day_pulse, 0);

    // Reach seconds 37, then set hours (with wrap) and minutes.
    for (int i = 0; i < 37; i++) begin
      do_tick();
      idle_cycle();
    end
    press_mode();
    check("sethr_mode", mode, 1);
    for (int i = 0; i < 25; i++) press_inc();
    check_time("sethr", 1, 0, 37);
    press_mode();
    for (int i = 0; i < 61; i++) press_inc();
    check("setmin_mode", mode, 2);
    check_time("setmin", 1, 1, 37);
    press_mode();
    check("exit_mode", mode, 0);
    check_time("exit", 1, 1, 0);
    do_tick();
    check_time("exit_tick", 1, 1, 1);
    idle_cycle();

    // Idle timeout with blink phase.
    press_mode();
    check("to_bhr0", blank_hr, 0);
    do_tick();
    check("to_bhr1", blank_hr, 1);
    idle_cycle();
    do_tick();
    check("to_bhr2", blank_hr, 0);
    check("to_mode2", mode, 1);
    idle_cycle();
    do_tick();
    check("to_mode3", mode, 0);
    check_time("to_time", 1, 1, 0);
    idle_cycle();

    // Simultaneous mode+inc press, then inc press coincident with tick.
    step(0, 0, 1, 1);
    check("both_mode", mode, 1);
    check_time("both", 1, 1, 0);
    idle_cycle();
    do_tick();
    check("co_bhr_pre", blank_hr, 1);
    step(0, 1, 0, 1);
    check_time("co_inc", 2, 1, 0);
    check("co_bhr", blank_hr, 0);
    check("co_mode", mode, 1);
    idle_cycle();
    do_tick();
    idle_cycle();
    do_tick();
    check("co_no_to", mode, 1);
    idle_cycle();
    do_tick();
    check("co_to", mode, 0);
    idle_cycle();

    // Mode button held through reset release.
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    check("held_mode", mode, 0);
    idle_cycle();
    press_mode();
    check("held_press", mode, 1);
    press_inc();
    press_mode();
    press_inc();
    check("rst_setmin", mode, 2);
    check_time("pre_rst", 1, 1, 0);
    step(1, 0, 0, 0);
    check("rst_mid_mode", mode, 0);
    check_time("rst_mid", 0, 0, 0);
    idle_cycle();
    idle_cycle();
    check("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Time-keeping and time-setting controller for the digital clock. It owns the HH:MM:SS BCD time registers and advances them on a 1 Hz enable, with the full carry chain across seconds, minutes and hours. It runs a mode state machine driven by two pre-debounced buttons so the user can set hours and minutes, and it generates blanking strobes for the display driver. It sits between the prescaler (tick source) and the seven-segment multiplexer.

## Interface
- SET_TIMEOUT, 30: number of ticks with no button press in a set state before returning to RUN (1..255).
- clk  input  1  system clock.
- reset  input  1  reset, synchronous, active-high; clock clk.
- tick  input  1  one-cycle 1 Hz enable pulse from prescaler.
- btn_mode  input  1  mode button level, debounced, synchronous to clk.
- btn_inc  input  1  increment button level, debounced, synchronous to clk.
- hr_t  output  2  hours tens digit, BCD 0..2.
- hr_u  output  4  hours units digit, BCD 0..9.
- min_t  output  3  minutes tens digit, BCD 0..5.
- min_u  output  4  minutes units digit, BCD 0..9.
- sec_t  output  3  seconds tens digit, BCD 0..5.
- sec_u  output  4  seconds units digit, BCD 0..9.
- mode  output  2  state: 0 RUN, 1 SET_HR, 2 SET_MIN.
- blank_hr  output  1  blank hour digits (blink).
- blank_min  output  1  blank minute digits (blink).
- day_pulse  output  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover.

## Operation
- Press detect: press = btn & ~btn_q, with btn_q a registered copy. btn_q resets to 1, so a button held through reset registers no press.
- RUN: on tick, sec_u +1. 9 -> 0 carries into sec_t. 59 -> 00 carries into min_u/min_t. Minutes 59 -> 00 carries into hours. Hours follow 09 -> 10, 19 -> 20, 23 -> 00. 23:59:59 + tick -> 00:00:00 and day_pulse = 1 for that cycle.
- RUN + mode press -> SET_HR. Seconds freeze.
- SET_HR: tick does not advance time. Inc press -> hours +1, wrapping 23 -> 00. Minutes and seconds are unaffected. Mode press -> SET_MIN.
- SET_MIN: inc press -> minutes +1, wrapping 59 -> 00 with no carry into hours. Mode press -> RUN, and seconds clear to 00 on the same edge.
- Timeout: an 8-bit idle counter clears on entry to a set state and on any press. It increments on each tick in a set state. When the counter reaches SET_TIMEOUT, the state goes to RUN and seconds clear to 00. The counter holds at 0 in RUN.
- Blink: a phase bit clears on entry to a set state and on inc press, and toggles on each tick in a set state.
  - blank_hr = (mode==SET_HR) & phase.
  - blank_min = (mode==SET_MIN) & phase.
- Simultaneous events:
  - mode and inc pressed in the same cycle: mode wins, inc is ignored.
  - inc press and tick in the same cycle in a set state: the increment is applied, the idle counter clears, and phase clears.
  - tick in the cycle of the RUN -> SET_HR transition: the tick is ignored (no second advance).
- Digits never hold illegal BCD values; hours never exceed 23.

## Timing
- All outputs are registered.
- Reset values: time 00:00:00, mode 0, blank_hr 0, blank_min 0, day_pulse 0, idle counter 0, phase 0.
- Reset applied mid-set returns to RUN at 00:00:00 on the next edge.
- Tick or press sampled at edge N: the resulting time, mode and blank values are visible after edge N (latency 1 cycle from input assertion).
- day_pulse is high exactly the one cycle following the rollover edge.
- A press requires btn low for at least one sampled cycle before the next press.

## Test plan
- Reset, then 61 ticks -> 00:01:01. Hold 23:59:58, 2 ticks -> 00:00:00, day_pulse high for 1 cycle.
- Mode press, 25 inc presses -> mode 1, hours 01 (23 -> 00 wrap seen). Mode press, 61 inc presses -> mode 2, minutes 01, hours unchanged at 01.
- From SET_MIN with seconds = 37, mode press -> mode 0, seconds 00. The next tick gives 00 -> 01.
- In SET_HR, no presses for SET_TIMEOUT=3 ticks -> mode 0 after the third tick. blank_hr toggles 0, 1, 0 on successive ticks.
- btn_mode and btn_inc rise in the same cycle in RUN -> mode 1, hours unchanged. inc press and tick coincident in SET_HR -> hours +1, blank_hr 0, no timeout.
- btn_mode held high through reset release -> no mode change until the button is released and pressed again. Reset asserted in SET_MIN -> 00:00:00, mode 0.
